// File: rtl/unit_lock_pool_arbiter.sv
// Lease manager granting NUM_UNITS shared execution units to NUM_PORTS requesters,
// oldest issue id first, with bounded hold time, rollback flush and release cooldown.
module unit_lock_pool_arbiter #(
    parameter  int unsigned NUM_PORTS   = 8,
    parameter  int unsigned NUM_UNITS   = 4,
    parameter  int unsigned ID_WIDTH    = 16,
    parameter  int unsigned MAX_HOLD    = 0,
    parameter  int unsigned RELEASE_GAP = 0,
    localparam int unsigned PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int unsigned UNIT_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS*ID_WIDTH-1:0] req_id,
    input  logic                          flush_valid,
    input  logic [ID_WIDTH-1:0]           flush_id,
    output logic [NUM_PORTS-1:0]          grant,
    output logic [NUM_PORTS*UNIT_W-1:0]   grant_unit,
    output logic [NUM_PORTS-1:0]          revoke,
    output logic [NUM_UNITS-1:0]          unit_busy,
    output logic [NUM_UNITS*PORT_W-1:0]   unit_owner
);
    localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int unsigned COOL_W = (RELEASE_GAP > 0) ? $clog2(RELEASE_GAP + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        COOL = 2'd2
    } unit_state_e;

    unit_state_e                 state_q    [NUM_UNITS];
    unit_state_e                 state_d    [NUM_UNITS];
    logic [PORT_W-1:0]           owner_q    [NUM_UNITS];
    logic [PORT_W-1:0]           owner_d    [NUM_UNITS];
    logic [ID_WIDTH-1:0]         hold_id_q  [NUM_UNITS];
    logic [ID_WIDTH-1:0]         hold_id_d  [NUM_UNITS];
    logic [HOLD_W-1:0]           hold_cnt_q [NUM_UNITS];
    logic [HOLD_W-1:0]           hold_cnt_d [NUM_UNITS];
    logic [COOL_W-1:0]           cool_cnt_q [NUM_UNITS];
    logic [COOL_W-1:0]           cool_cnt_d [NUM_UNITS];
    logic [ID_WIDTH-1:0]         port_id    [NUM_PORTS];

    logic [NUM_PORTS-1:0]        blocked_q;
    logic [NUM_PORTS-1:0]        blocked_d;
    logic [NUM_PORTS-1:0]        revoke_d;
    logic [NUM_PORTS-1:0]        grant_d;
    logic [NUM_PORTS*UNIT_W-1:0] grant_unit_d;
    logic [NUM_UNITS-1:0]        unit_busy_d;
    logic [NUM_UNITS*PORT_W-1:0] unit_owner_d;
    logic [NUM_PORTS-1:0]        cand;
    logic                        found;
    int                          best;

    // Wrap-aware age compare: a is older than b when (a - b) is negative as a signed value.
    function automatic logic is_older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
        logic [ID_WIDTH-1:0] diff;
        diff = a - b;
        return diff[ID_WIDTH-1];
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_id[p] = req_id[p*ID_WIDTH +: ID_WIDTH];
        end
    end

    // State register: per-unit lease state plus all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                state_q[u]    <= IDLE;
                owner_q[u]    <= '0;
                hold_id_q[u]  <= '0;
                hold_cnt_q[u] <= '0;
                cool_cnt_q[u] <= '0;
            end
            blocked_q  <= '0;
            grant      <= '0;
            grant_unit <= '0;
            revoke     <= '0;
            unit_busy  <= '0;
            unit_owner <= '0;
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                state_q[u]    <= state_d[u];
                owner_q[u]    <= owner_d[u];
                hold_id_q[u]  <= hold_id_d[u];
                hold_cnt_q[u] <= hold_cnt_d[u];
                cool_cnt_q[u] <= cool_cnt_d[u];
            end
            blocked_q  <= blocked_d;
            grant      <= grant_d;
            grant_unit <= grant_unit_d;
            revoke     <= revoke_d;
            unit_busy  <= unit_busy_d;
            unit_owner <= unit_owner_d;
        end
    end

    // Next state: lease end (release/timeout/flush), cooldown, and oldest-first allocation.
    always_comb begin
        cand      = req_valid & ~grant & ~blocked_q;
        blocked_d = blocked_q & req_valid;
        revoke_d  = '0;
        found     = 1'b0;
        best      = 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (flush_valid && is_older(flush_id, port_id[p])) begin
                cand[p] = 1'b0;
            end
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            state_d[u]    = state_q[u];
            owner_d[u]    = owner_q[u];
            hold_id_d[u]  = hold_id_q[u];
            hold_cnt_d[u] = hold_cnt_q[u];
            cool_cnt_d[u] = cool_cnt_q[u];
            case (state_q[u])
                IDLE: begin
                    found = 1'b0;
                    best  = 0;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (cand[p] && (!found || is_older(port_id[p], port_id[best]))) begin
                            found = 1'b1;
                            best  = p;
                        end
                    end
                    if (found) begin
                        state_d[u]    = HELD;
                        owner_d[u]    = PORT_W'(best);
                        hold_id_d[u]  = port_id[best];
                        hold_cnt_d[u] = HOLD_W'(1);
                        cand[best]    = 1'b0;
                    end
                end
                HELD: begin
                    if (!req_valid[owner_q[u]] ||
                        ((MAX_HOLD != 0) && (hold_cnt_q[u] == HOLD_W'(MAX_HOLD))) ||
                        (flush_valid && is_older(flush_id, hold_id_q[u]))) begin
                        state_d[u]    = (RELEASE_GAP == 0) ? IDLE : COOL;
                        cool_cnt_d[u] = COOL_W'(RELEASE_GAP);
                        hold_cnt_d[u] = '0;
                        // A voluntary release on the same edge suppresses the revoke.
                        if (req_valid[owner_q[u]]) begin
                            revoke_d[owner_q[u]]  = 1'b1;
                            blocked_d[owner_q[u]] = 1'b1;
                        end
                    end else if (MAX_HOLD != 0) begin
                        hold_cnt_d[u] = HOLD_W'(hold_cnt_q[u] + 1'b1);
                    end
                end
                COOL: begin
                    if (cool_cnt_q[u] <= COOL_W'(1)) begin
                        state_d[u]    = IDLE;
                        cool_cnt_d[u] = '0;
                    end else begin
                        cool_cnt_d[u] = COOL_W'(cool_cnt_q[u] - 1'b1);
                    end
                end
                default: state_d[u] = IDLE;
            endcase
        end
    end

    // Output decode of the next state, registered alongside it.
    always_comb begin
        grant_d      = '0;
        grant_unit_d = '0;
        unit_busy_d  = '0;
        unit_owner_d = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_busy_d[u] = (state_d[u] != IDLE);
            if (state_d[u] == HELD) begin
                grant_d[owner_d[u]]                                 = 1'b1;
                grant_unit_d[int'(owner_d[u]) * UNIT_W +: UNIT_W]   = UNIT_W'(u);
                unit_owner_d[u * PORT_W +: PORT_W]                  = owner_d[u];
            end
        end
    end

endmodule

// File: tb/tb_unit_lock_pool_arbiter.sv
// Scoreboard bench for unit_lock_pool_arbiter: three parameterisations driven by
// directed vectors; expected per-cycle outputs are queued and checked by a monitor.
module tb_unit_lock_pool_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: 4 ports, 2 units, no hold limit, no cooldown
    logic [3:0]  a_req_valid;
    logic [63:0] a_req_id;
    logic        a_flush_valid;
    logic [15:0] a_flush_id;
    logic [3:0]  a_grant;
    logic [3:0]  a_grant_unit;
    logic [3:0]  a_revoke;
    logic [1:0]  a_unit_busy;
    logic [3:0]  a_unit_owner;

    // Instance B: 8 ports, 4 units, MAX_HOLD=4
    logic [7:0]   b_req_valid;
    logic [127:0] b_req_id;
    logic         b_flush_valid;
    logic [15:0]  b_flush_id;
    logic [7:0]   b_grant;
    logic [15:0]  b_grant_unit;
    logic [7:0]   b_revoke;
    logic [3:0]   b_unit_busy;
    logic [11:0]  b_unit_owner;

    // Instance C: 2 ports, 1 unit, RELEASE_GAP=2
    logic [1:0]  c_req_valid;
    logic [31:0] c_req_id;
    logic        c_flush_valid;
    logic [15:0] c_flush_id;
    logic [1:0]  c_grant;
    logic [1:0]  c_grant_unit;
    logic [1:0]  c_revoke;
    logic [0:0]  c_unit_busy;
    logic [0:0]  c_unit_owner;

    unit_lock_pool_arbiter #(.NUM_PORTS(4), .NUM_UNITS(2), .ID_WIDTH(16), .MAX_HOLD(0), .RELEASE_GAP(0)) dut_a (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_id(a_req_id),
        .flush_valid(a_flush_valid), .flush_id(a_flush_id), .grant(a_grant),
        .grant_unit(a_grant_unit), .revoke(a_revoke), .unit_busy(a_unit_busy), .unit_owner(a_unit_owner)
    );

    unit_lock_pool_arbiter #(.NUM_PORTS(8), .NUM_UNITS(4), .ID_WIDTH(16), .MAX_HOLD(4), .RELEASE_GAP(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_id(b_req_id),
        .flush_valid(b_flush_valid), .flush_id(b_flush_id), .grant(b_grant),
        .grant_unit(b_grant_unit), .revoke(b_revoke), .unit_busy(b_unit_busy), .unit_owner(b_unit_owner)
    );

    unit_lock_pool_arbiter #(.NUM_PORTS(2), .NUM_UNITS(1), .ID_WIDTH(16), .MAX_HOLD(0), .RELEASE_GAP(2)) dut_c (
        .clk(clk), .reset(reset), .req_valid(c_req_valid), .req_id(c_req_id),
        .flush_valid(c_flush_valid), .flush_id(c_flush_id), .grant(c_grant),
        .grant_unit(c_grant_unit), .revoke(c_revoke), .unit_busy(c_unit_busy), .unit_owner(c_unit_owner)
    );

    logic [7:0]  act_g    [3];
    logic [15:0] act_gu   [3];
    logic [7:0]  act_rv   [3];
    logic [3:0]  act_busy [3];
    logic [11:0] act_own  [3];

    assign act_g[0]    = 8'(a_grant);
    assign act_g[1]    = b_grant;
    assign act_g[2]    = 8'(c_grant);
    assign act_gu[0]   = 16'(a_grant_unit);
    assign act_gu[1]   = b_grant_unit;
    assign act_gu[2]   = 16'(c_grant_unit);
    assign act_rv[0]   = 8'(a_revoke);
    assign act_rv[1]   = b_revoke;
    assign act_rv[2]   = 8'(c_revoke);
    assign act_busy[0] = 4'(a_unit_busy);
    assign act_busy[1] = b_unit_busy;
    assign act_busy[2] = 4'(c_unit_busy);
    assign act_own[0]  = 12'(a_unit_owner);
    assign act_own[1]  = b_unit_owner;
    assign act_own[2]  = 12'(c_unit_owner);

    typedef struct {
        int          cyc;
        int          inst;
        string       tag;
        logic [7:0]  g;
        logic [15:0] gu;
        logic [7:0]  rv;
        logic [3:0]  busy;
    } exp_t;

    exp_t sbq[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic int ports_of(input int i);
        case (i)
            0:       return 4;
            1:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic int uw_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int pw_of(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    task automatic cmp(input string tag, input string what, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s/%s: actual 0x%0h, expected 0x%0h (t=%0t)", tag, what, act, exp_v, $time);
        end
    endtask

    task automatic push(input int inst, input string tag, input logic [7:0] g,
                        input logic [15:0] gu, input logic [7:0] rv, input logic [3:0] busy);
        exp_t e;
        e.cyc  = cyc + 1;
        e.inst = inst;
        e.tag  = tag;
        e.g    = g;
        e.gu   = gu;
        e.rv   = rv;
        e.busy = busy;
        sbq.push_back(e);
    endtask

    task automatic step(input int inst, input string tag, input logic [7:0] g,
                        input logic [15:0] gu, input logic [7:0] rv, input logic [3:0] busy);
        push(inst, tag, g, gu, rv, busy);
        @(negedge clk);
    endtask

    // Monitor: one registered output set per edge; pop and compare what was queued for it.
    exp_t mon_e;
    int   mon_i, mon_w, mon_pw, mon_eu, mon_au, mon_ao;
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_e = sbq.pop_front();
            mon_i = mon_e.inst;
            cmp(mon_e.tag, "grant", int'(act_g[mon_i]), int'(mon_e.g));
            cmp(mon_e.tag, "revoke", int'(act_rv[mon_i]), int'(mon_e.rv));
            cmp(mon_e.tag, "unit_busy", int'(act_busy[mon_i]), int'(mon_e.busy));
            mon_w  = uw_of(mon_i);
            mon_pw = pw_of(mon_i);
            for (int p = 0; p < ports_of(mon_i); p++) begin
                if (mon_e.g[p]) begin
                    mon_eu = (32'(mon_e.gu) >> (p * mon_w)) & ((1 << mon_w) - 1);
                    mon_au = (32'(act_gu[mon_i]) >> (p * mon_w)) & ((1 << mon_w) - 1);
                    cmp(mon_e.tag, "grant_unit", mon_au, mon_eu);
                    mon_ao = (32'(act_own[mon_i]) >> (mon_eu * mon_pw)) & ((1 << mon_pw) - 1);
                    cmp(mon_e.tag, "unit_owner", mon_ao, p);
                end
            end
        end
    end

    task automatic set_a(input int p, input logic v, input logic [15:0] id);
        a_req_valid[p]          = v;
        a_req_id[p*16 +: 16]    = id;
    endtask

    task automatic set_b(input int p, input logic v, input logic [15:0] id);
        b_req_valid[p]          = v;
        b_req_id[p*16 +: 16]    = id;
    endtask

    task automatic set_c(input int p, input logic v, input logic [15:0] id);
        c_req_valid[p]          = v;
        c_req_id[p*16 +: 16]    = id;
    endtask

    initial begin
        reset         = 1'b1;
        a_req_valid   = '0; a_req_id = '0; a_flush_valid = 1'b0; a_flush_id = '0;
        b_req_valid   = '0; b_req_id = '0; b_flush_valid = 1'b0; b_flush_id = '0;
        c_req_valid   = '0; c_req_id = '0; c_flush_valid = 1'b0; c_flush_id = '0;

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cmp("reset", "grant", int'(act_g[i]), 0);
            cmp("reset", "unit_busy", int'(act_busy[i]), 0);
        end
        cmp("reset", "revoke_b", int'(act_rv[1]), 0);
        reset = 1'b0;
        push(0, "idle", 8'h00, 16'h0000, 8'h00, 4'h0);
        push(1, "idle", 8'h00, 16'h0000, 8'h00, 4'h0);
        step(2, "idle", 8'h00, 16'h0000, 8'h00, 4'h0);

        // Oldest first across two units, release then reallocation one edge later
        set_a(0, 1'b1, 16'd5); set_a(1, 1'b1, 16'd3); set_a(2, 1'b1, 16'd9);
        step(0, "t1_alloc",   8'h03, 16'h0001, 8'h00, 4'h3);
        set_a(1, 1'b0, 16'd3);
        step(0, "t1_release", 8'h01, 16'h0001, 8'h00, 4'h2);
        step(0, "t1_realloc", 8'h05, 16'h0001, 8'h00, 4'h3);
        a_req_valid = '0;
        step(0, "t1_drop",    8'h00, 16'h0000, 8'h00, 4'h0);

        // Wrap-around age compare, then cooldown of two cycles before the waiter is served
        set_c(0, 1'b1, 16'h0001); set_c(1, 1'b1, 16'hFFFE);
        step(2, "t2_wrap",     8'h02, 16'h0000, 8'h00, 4'h1);
        set_c(1, 1'b0, 16'hFFFE);
        step(2, "t5_cool1",    8'h00, 16'h0000, 8'h00, 4'h1);
        step(2, "t5_cool2",    8'h00, 16'h0000, 8'h00, 4'h1);
        step(2, "t5_idle",     8'h00, 16'h0000, 8'h00, 4'h0);
        step(2, "t5_grant",    8'h01, 16'h0000, 8'h00, 4'h1);
        c_req_valid = '0;
        step(2, "t5_rel",      8'h00, 16'h0000, 8'h00, 4'h1);
        step(2, "t5_rel_cool", 8'h00, 16'h0000, 8'h00, 4'h1);
        step(2, "t5_rel_idle", 8'h00, 16'h0000, 8'h00, 4'h0);
        set_c(0, 1'b1, 16'h1234); set_c(1, 1'b1, 16'h1234);
        step(2, "tie",         8'h01, 16'h0000, 8'h00, 4'h1);
        c_req_valid = '0;
        step(2, "tie_rel",     8'h00, 16'h0000, 8'h00, 4'h1);

        // Hold limit: four cycles of grant, revoke pulse, blocked until req_valid drops
        set_b(3, 1'b1, 16'd7);
        step(1, "t3_hold1",    8'h08, 16'h0000, 8'h00, 4'h1);
        step(1, "t3_hold2",    8'h08, 16'h0000, 8'h00, 4'h1);
        step(1, "t3_hold3",    8'h08, 16'h0000, 8'h00, 4'h1);
        step(1, "t3_hold4",    8'h08, 16'h0000, 8'h00, 4'h1);
        step(1, "t3_timeout",  8'h00, 16'h0000, 8'h08, 4'h0);
        step(1, "t3_blocked1", 8'h00, 16'h0000, 8'h00, 4'h0);
        step(1, "t3_blocked2", 8'h00, 16'h0000, 8'h00, 4'h0);
        set_b(3, 1'b0, 16'd7);
        step(1, "t3_low",      8'h00, 16'h0000, 8'h00, 4'h0);
        set_b(3, 1'b1, 16'd7);
        step(1, "t3_regrant",  8'h08, 16'h0000, 8'h00, 4'h1);
        set_b(3, 1'b0, 16'd7);
        step(1, "t3_drop",     8'h00, 16'h0000, 8'h00, 4'h0);

        // Release on the timeout edge wins: no revoke, no block
        set_b(5, 1'b1, 16'd1);
        step(1, "rw_hold1",   8'h20, 16'h0000, 8'h00, 4'h1);
        step(1, "rw_hold2",   8'h20, 16'h0000, 8'h00, 4'h1);
        step(1, "rw_hold3",   8'h20, 16'h0000, 8'h00, 4'h1);
        step(1, "rw_hold4",   8'h20, 16'h0000, 8'h00, 4'h1);
        set_b(5, 1'b0, 16'd1);
        step(1, "rw_release", 8'h00, 16'h0000, 8'h00, 4'h0);
        set_b(5, 1'b1, 16'd1);
        step(1, "rw_regrant", 8'h20, 16'h0000, 8'h00, 4'h1);
        set_b(5, 1'b0, 16'd1);
        step(1, "rw_drop",    8'h00, 16'h0000, 8'h00, 4'h0);

        // Flush revokes only the strictly younger latched holder; younger candidate waits
        set_b(0, 1'b1, 16'd30); set_b(1, 1'b1, 16'd10); set_b(2, 1'b1, 16'd20);
        step(1, "t4_alloc", 8'h07, 16'h0012, 8'h00, 4'h7);
        set_b(0, 1'b1, 16'd15);
        set_b(3, 1'b1, 16'd25);
        b_flush_valid = 1'b1;
        b_flush_id    = 16'd20;
        step(1, "t4_flush", 8'h06, 16'h0012, 8'h01, 4'h3);
        b_flush_valid = 1'b0;
        step(1, "t4_after", 8'h0E, 16'h0092, 8'h00, 4'h7);
        b_req_valid = '0;
        step(1, "t4_drop",  8'h00, 16'h0000, 8'h00, 4'h0);

        // Asynchronous reset mid-lease clears outputs without waiting for an edge
        set_a(0, 1'b1, 16'd1);
        step(0, "t6_grant", 8'h01, 16'h0000, 8'h00, 4'h1);
        #2;
        reset = 1'b1;
        #1;
        cmp("t6_async", "grant", int'(a_grant), 0);
        cmp("t6_async", "grant_unit", int'(a_grant_unit), 0);
        cmp("t6_async", "revoke", int'(a_revoke), 0);
        cmp("t6_async", "unit_busy", int'(a_unit_busy), 0);
        cmp("t6_async", "unit_owner", int'(a_unit_owner), 0);
        @(negedge clk);
        reset = 1'b0;
        step(0, "t6_after", 8'h01, 16'h0000, 8'h00, 4'h1);
        a_req_valid = '0;
        step(0, "t6_drop",  8'h00, 16'h0000, 8'h00, 4'h0);

        repeat (3) @(negedge clk);
        cmp("end", "scoreboard_pending", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unit_lock_pool_arbiter.md
Name: unit_lock_pool_arbiter

Overview:
- Parametrised successor to the fixed ALU/MDU lock pools: a generic lease manager granting NUM_UNITS shared execution units to NUM_PORTS SIC requesters.
- Grants go oldest-issue-id first, with wrap-aware age compare.
- Adds what the fixed pools lack: bounded lease time with forced revoke, rollback flush of younger holders, and a configurable post-release cooldown.
- Sits between the SIC array and any unit array. Lease control only; the unit datapath is external.

Parameters:
NUM_PORTS, 8, number of requesting SICs
NUM_UNITS, 4, number of shared units (1..NUM_PORTS)
ID_WIDTH, 16, issue-id width
MAX_HOLD, 0, max cycles a lease may be held (0 = unlimited)
RELEASE_GAP, 0, cooldown cycles a unit stays unavailable after release/revoke
PORT_W, derived, max(1, clog2(NUM_PORTS))
UNIT_W, derived, max(1, clog2(NUM_UNITS))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  NUM_PORTS  port requests/holds a unit while high
req_id  in  NUM_PORTS*ID_WIDTH  issue id per port
flush_valid  in  1  rollback pulse
flush_id  in  ID_WIDTH  surviving instruction id; strictly younger holders are revoked
grant  out  NUM_PORTS  port currently holds a unit
grant_unit  out  NUM_PORTS*UNIT_W  unit index held (valid when grant)
revoke  out  NUM_PORTS  one-cycle pulse: lease forcibly ended
unit_busy  out  NUM_UNITS  unit not IDLE
unit_owner  out  NUM_UNITS*PORT_W  holding port (valid when HELD)

Behaviour:
- Reset (async, any cycle, including mid-lease) zeroes the following: grant, grant_unit, revoke, unit_busy, unit_owner, hold counters, cooldown counters, blocked flags. All units go IDLE.
- Per-unit FSM has three states: IDLE, HELD, COOL.
  - IDLE->HELD on allocation.
  - HELD->COOL (or IDLE if RELEASE_GAP=0) on release or revoke.
  - COOL counts RELEASE_GAP cycles, then goes IDLE.
- Age compare: a is older than b iff (a-b) mod 2^ID_WIDTH, read as signed, is negative. Ties go to the lower port index.
- Candidates are ports with req_valid=1, grant=0, blocked=0. Candidates with id younger than flush_id are excluded in the cycle flush_valid=1.
- Allocation: k = number of IDLE units. The k oldest candidates get IDLE units, in ascending unit index, oldest first.
- All outputs are registered: request at edge N gives grant=1 after edge N+1 (1-cycle latency).
- Holder id is latched at grant. req_id changes during a lease are ignored.
- Units freed at an edge are not reallocated at the same edge.
- Release: req_valid=0 while grant=1 gives grant=0 after the next edge. No revoke pulse.
- MAX_HOLD>0: hold counter increments each HELD cycle. When grant has been high MAX_HOLD cycles, the next edge does three things:
  - drops grant;
  - pulses revoke for 1 cycle;
  - sets blocked for that port.
- Flush: at an edge with flush_valid=1, every holder whose latched id is strictly younger than flush_id is revoked. Same effect as a timeout revoke.
- blocked clears only when the port drops req_valid for at least 1 cycle, so a revoked port cannot re-acquire without a fresh request.
- Simultaneous release and revoke at one edge: release wins, no revoke pulse.
- Simultaneous timeout and flush on one holder: a single revoke pulse.
- Invariants:
  - each unit has at most one owner;
  - each port holds at most one unit;
  - popcount(grant) <= NUM_UNITS.

Test Plan:
1. NUM_UNITS=2. Ports 0,1,2 request ids 5,3,9 at cycle 0 -> after edge 1: ports 1 (unit0) and 0 (unit1) granted, port 2 waits. Port 1 drops req -> port 2 gets unit0 two edges later (release edge, then allocation edge).
2. Wrap-around: ids 0xFFFE vs 0x0001 contending for 1 unit -> 0xFFFE granted.
3. MAX_HOLD=4, port 3 holds continuously -> grant high exactly 4 cycles, revoke pulse 1 cycle. No regrant while req_valid stays high; regrant 1 cycle after req_valid re-asserts following a low cycle.
4. Holders with ids 10, 20, 30; flush_valid with flush_id=20 -> only the id-30 holder is revoked. Pending request id 25 is not granted in the flush cycle.
5. RELEASE_GAP=2, single unit, release and waiting requester -> unit_busy stays high 2 cooldown cycles. Waiter granted 4 edges after req_valid dropped.
6. Reset asserted asynchronously mid-lease -> all outputs 0 immediately, no revoke pulse. Requests after deassert are granted normally.
